// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with hold-until-done grants.
// Optional forced release after MAX_HOLD cycles under `RR_ARB_TIMEOUT_EN.
module rr_arbiter16 #(
    parameter int N        = 16,
    parameter int IDW      = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    if (N != 16 || IDW != 4 || MAX_HOLD < 1) begin : g_cfg_err
        $error("rr_arbiter16: unsupported parameter set");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic           valid_q, valid_d;
    logic           tmo_q, tmo_d;

    logic [IDW-1:0] win_hi, win_lo, winner;
    logic           hit_hi;
    logic           hold_hit;
    logic           own_req;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_lo = IDW'(i);
                if (IDW'(i) >= ptr_q) begin
                    win_hi = IDW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        winner = hit_hi ? win_hi : win_lo;
    end

    assign own_req = req[id_q];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;

    // Compare the post-increment count so release lands after MAX_HOLD grant cycles.
    assign hold_hit = (state_q == GRANT) &&
                      ((hold_q + HW'(1)) == HW'(MAX_HOLD));

    always_comb begin
        hold_d = '0;
        if (state_q == GRANT) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        valid_d = valid_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << winner;
                    id_d    = winner;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (done || !own_req || hold_hit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = id_q + IDW'(1);
                    tmo_d   = hold_hit && !done && own_req;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign gnt_id    = id_q;
    assign busy      = valid_q;
    assign timeout   = tmo_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed-vector bench for rr_arbiter16.
// Covers reset, rotation, withdraw, async reset and optional timeout.
module tb_rr_arbiter16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic [3:0]  gnt_id;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter16 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    // Output consistency on every falling edge outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid_eq_or_gnt", 32'(gnt_valid), 32'(|gnt));
            check("busy_eq_valid", 32'(busy), 32'(gnt_valid));
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        end
    end

    logic [15:0] oh;

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        #3;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_id", 32'(gnt_id), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        #9;
        rst = 1'b0;

        for (int c = 0; c < 5; c++) begin
            tick();
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_valid", 32'(gnt_valid), 32'h0);
            check("idle_id", 32'(gnt_id), 32'h0);
        end

        req = 16'h0090;
        tick();
        check("g4_gnt", 32'(gnt), 32'h0010);
        check("g4_id", 32'(gnt_id), 32'd4);
        check("g4_valid", 32'(gnt_valid), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("g4_rel_valid", 32'(gnt_valid), 32'd0);
        check("g4_rel_id", 32'(gnt_id), 32'd4);
        tick();
        check("g7_gnt", 32'(gnt), 32'h0080);
        check("g7_id", 32'(gnt_id), 32'd7);
        req = 16'h0000;
        tick();
        check("g7_rel_valid", 32'(gnt_valid), 32'd0);

        do_reset();
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            tick();
            oh = 16'h0001 << (i % 16);
            check("rr_valid", 32'(gnt_valid), 32'd1);
            check("rr_id", 32'(gnt_id), 32'(i % 16));
            check("rr_gnt", 32'(gnt), 32'(oh));
            done = 1'b1;
            tick();
            done = 1'b0;
            check("rr_gap", 32'(gnt_valid), 32'd0);
        end

        req = 16'h0008;
        tick();
        check("w3_id", 32'(gnt_id), 32'd3);
        check("w3_gnt", 32'(gnt), 32'h0008);
        req = 16'h0000;
        tick();
        check("w3_rel_valid", 32'(gnt_valid), 32'd0);
        check("w3_rel_id", 32'(gnt_id), 32'd3);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("w3_idle_valid", 32'(gnt_valid), 32'd0);
        check("w3_idle_id", 32'(gnt_id), 32'd3);

        req = 16'h0200;
        tick();
        check("g9_id", 32'(gnt_id), 32'd9);
        check("g9_valid", 32'(gnt_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_gnt", 32'(gnt), 32'h0);
        check("arst_valid", 32'(gnt_valid), 32'd0);
        check("arst_id", 32'(gnt_id), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        #2;
        req = 16'h0201;
        rst = 1'b0;
        tick();
        check("post_rst_id", 32'(gnt_id), 32'd0);
        check("post_rst_gnt", 32'(gnt), 32'h0001);
        req = 16'h0000;
        tick();
        check("post_rst_rel", 32'(gnt_valid), 32'd0);

        req = 16'h0001;
        tick();
        check("hold_valid_1", 32'(gnt_valid), 32'd1);
`ifdef RR_ARB_TIMEOUT_EN
        for (int k = 2; k <= 15; k++) begin
            tick();
            check("hold_valid", 32'(gnt_valid), 32'd1);
            check("hold_tmo", 32'(timeout), 32'd0);
        end
        tick();
        check("tmo_valid", 32'(gnt_valid), 32'd0);
        check("tmo_pulse", 32'(timeout), 32'd1);
        tick();
        check("tmo_regrant", 32'(gnt_valid), 32'd1);
        check("tmo_regrant_id", 32'(gnt_id), 32'd0);
        check("tmo_clear", 32'(timeout), 32'd0);
`else
        for (int k = 2; k <= 20; k++) begin
            tick();
            check("hold_valid", 32'(gnt_valid), 32'd1);
            check("hold_tmo", 32'(timeout), 32'd0);
        end
`endif
        req = 16'h0000;
        tick();
        check("final_rel", 32'(gnt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
